tile_grid_renderer: RTL and testbench
=====================================

Name: tile_grid_renderer

Overview:
- Parametrised successor to the per-tile renderer for the 2048 VGA display.
- Holds the GRID_N x GRID_N board values in registers and accepts writes and reads from game logic.
- For each pixel coordinate from vga_sync it returns, through a fixed 3-stage pipeline, whether the pixel lies on a rounded-corner tile and that tile's colour class, ready for color_blocker.
- Includes a sequential board-clear engine and an optional frame-synchronised shadow board.

Parameters:
GRID_N, 4, tiles per row and column
BLOCK_DIM, 64, tile edge in pixels
MARGIN, 10, gap between tiles and before the first tile
X_OFF, 40, left offset of the grid
Y_OFF, 0, top offset of the grid
RADIUS, 3, corner radius in pixels; 0 gives square corners
VAL_W, 4, width of a cell value / colour class
COORD_W, 10, pixel coordinate width

Ports:
iCLK  in  1  pixel clock (VGA_CTRL_CLK)
iRST  in  1  synchronous, active-high reset
iPX  in  COORD_W  pixel x (px from vga_sync)
iPY  in  COORD_W  pixel y
iPX_VALID  in  1  coordinate valid this cycle
iWR_EN  in  1  board write strobe
iWR_ROW  in  clog2(GRID_N)  write row
iWR_COL  in  clog2(GRID_N)  write column
iWR_VAL  in  VAL_W  write value
iRD_ROW  in  clog2(GRID_N)  read row
iRD_COL  in  clog2(GRID_N)  read column
oRD_VAL  out  VAL_W  registered read data
iCLEAR  in  1  start board clear (pulse)
oBUSY  out  1  clear in progress
iFRAME_START  in  1  frame boundary pulse (used only with the optional feature)
oVALID  out  1  pipeline output valid
oHIT  out  1  pixel is on a tile
oCLASS  out  VAL_W  tile value when oHIT=1, else 0

Behaviour:
- Reset state: all board cells 0, FSM IDLE. oBUSY, oVALID, oHIT, oCLASS and oRD_VAL are all 0. Pipeline valid bits are cleared. Reset mid-clear aborts the clear; the board is already 0.
- Tile geometry:
  - Column c spans x in [X_OFF+MARGIN+c*(BLOCK_DIM+MARGIN), that value+BLOCK_DIM-1], inclusive.
  - Row r spans y the same way using Y_OFF.
  - Column and row are found by parallel compares against elaborated constants; no dividers.
  - Local coordinates are rx = x - column start and ry = y - row start.
- Corner rule: a pixel is a corner pixel when (rx<RADIUS or rx>=BLOCK_DIM-RADIUS) and (ry<RADIUS or ry>=BLOCK_DIM-RADIUS).
  - dx = RADIUS-rx on the left, rx-(BLOCK_DIM-1-RADIUS) on the right; dy is the same using ry.
  - A corner pixel is kept only if dx*dx+dy*dy <= RADIUS*RADIUS.
  - Products use unsigned arithmetic at 2*COORD_W bits.
- Pipeline, latency exactly 3 cycles from iPX_VALID to oVALID:
  - S1 registers column/row hit flags, indices, rx and ry.
  - S2 reads the board cell and evaluates the corner rule.
  - S3 registers oHIT, oCLASS and oVALID.
  - oVALID follows iPX_VALID delayed by 3 cycles.
  - When oVALID=0, oHIT=0 and oCLASS=0.
  - No stalls; a new coordinate is accepted every cycle.
- Board access:
  - A write takes effect at the clock edge; a pixel reaching S2 on the next cycle sees the new value.
  - oRD_VAL = board[iRD_ROW][iRD_COL], registered, 1-cycle latency.
  - Read and write of the same cell in the same cycle returns the old value.
- Clear FSM:
  - IDLE: iCLEAR goes to CLEAR with index=0 and oBUSY=1.
  - CLEAR: writes 0 to cell[index] each cycle and increments index. After cell GRID_N*GRID_N-1 it goes to IDLE and oBUSY=0, so oBUSY is high for exactly GRID_N*GRID_N cycles.
  - iWR_EN while oBUSY=1 is ignored.
  - iCLEAR while busy is ignored.
  - iCLEAR together with iWR_EN in IDLE: the clear wins and the write is dropped.
  - Rendering continues during a clear; it shows a mix of old and cleared cells.

Optional Feature:
TILE_GRID_SHADOW_EN
- Defined:
  - Writes and clears go to a shadow board; the renderer reads the front board.
  - On iFRAME_START (with oBUSY=0) the shadow is copied to the front in one cycle.
  - If iFRAME_START arrives while busy, the copy is deferred to the first cycle after the clear ends.
  - oRD_VAL reads the shadow board.
- Undefined: a single board; iFRAME_START is ignored.

Test Plan:
1. Reset; write (row1,col2)=5; drive px=218, py=104 with valid -> 3 cycles later oVALID=1, oHIT=1, oCLASS=5.
2. Margin pixel px=118, py=20 -> oVALID=1, oHIT=0, oCLASS=0; with iPX_VALID=0 -> oVALID=0 three cycles later.
3. Cell (0,0)=3; pixels (50,10) -> oHIT=0; (51,11) -> oHIT=1, oCLASS=3; (50,13) -> oHIT=1; (113,73) -> oHIT=0.
4. Fill all 16 cells with 7; pulse iCLEAR -> oBUSY high for 16 cycles; write (2,2)=9 during busy is ignored; afterwards all 16 reads return 0.
5. iCLEAR and iWR_EN (0,1)=4 in the same IDLE cycle -> after the clear, oRD_VAL at (0,1)=0; assert iRST at cycle 5 of a clear -> oBUSY=0 next cycle, all cells 0.
6. With TILE_GRID_SHADOW_EN: front (3,3)=2; write (3,3)=9 -> a pixel on that tile still renders 2 and oRD_VAL=9; pulse iFRAME_START -> the tile renders 9.

Source files
------------

// File: rtl/tile_grid_renderer.sv
// Board register file, 3-stage rounded-tile pixel classifier and sequential clear engine.
// Optional TILE_GRID_SHADOW_EN: writes/clears target a shadow board copied to the front on frame start.
module tile_grid_renderer #(
  parameter int GRID_N    = 4,
  parameter int BLOCK_DIM = 64,
  parameter int MARGIN    = 10,
  parameter int X_OFF     = 40,
  parameter int Y_OFF     = 0,
  parameter int RADIUS    = 3,
  parameter int VAL_W     = 4,
  parameter int COORD_W   = 10,
  localparam int IDX_W    = (GRID_N > 1) ? $clog2(GRID_N) : 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [COORD_W-1:0] iPX,
  input  logic [COORD_W-1:0] iPY,
  input  logic               iPX_VALID,
  input  logic               iWR_EN,
  input  logic [IDX_W-1:0]   iWR_ROW,
  input  logic [IDX_W-1:0]   iWR_COL,
  input  logic [VAL_W-1:0]   iWR_VAL,
  input  logic [IDX_W-1:0]   iRD_ROW,
  input  logic [IDX_W-1:0]   iRD_COL,
  output logic [VAL_W-1:0]   oRD_VAL,
  input  logic               iCLEAR,
  output logic               oBUSY,
  input  logic               iFRAME_START,
  output logic               oVALID,
  output logic               oHIT,
  output logic [VAL_W-1:0]   oCLASS
);

  localparam int CELLS  = GRID_N * GRID_N;
  localparam int CNT_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int PITCH  = BLOCK_DIM + MARGIN;
  localparam int PROD_W = 2 * COORD_W;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  function automatic logic [COORD_W-1:0] span_start(input int off, input int k);
    return COORD_W'(off + MARGIN + k * PITCH);
  endfunction

  function automatic logic in_span(input logic [COORD_W-1:0] p, input int off, input int k);
    return (p >= span_start(off, k)) && (p <= span_start(off, k) + COORD_W'(BLOCK_DIM - 1));
  endfunction

  function automatic logic [CNT_W-1:0] cell_idx(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return CNT_W'(r) * CNT_W'(GRID_N) + CNT_W'(c);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   clr_idx_q, clr_idx_d;
  logic               clr_we_s, usr_we_s, busy_s;
  logic [VAL_W-1:0]   wr_board_q [CELLS];
  logic [VAL_W-1:0]   rd_val_q;
  logic [VAL_W-1:0]   px_cell_s;

  logic               col_hit_s, row_hit_s;
  logic [IDX_W-1:0]   col_s, row_s;
  logic [COORD_W-1:0] rx_s, ry_s;
  logic               s1_valid_q, s1_col_hit_q, s1_row_hit_q;
  logic [IDX_W-1:0]   s1_col_q, s1_row_q;
  logic [COORD_W-1:0] s1_rx_q, s1_ry_q;

  logic               left_s, right_s, top_s, bot_s, corner_s, keep_s;
  logic [COORD_W-1:0] dx_s, dy_s;
  logic [PROD_W-1:0]  dsq_s;
  logic               s2_valid_q, s2_hit_q;
  logic [VAL_W-1:0]   s2_val_q;

  logic               out_valid_q, out_hit_q;
  logic [VAL_W-1:0]   out_class_q;

  assign busy_s   = (state_q == ST_CLEAR);
  assign usr_we_s = iWR_EN && !busy_s && !iCLEAR;

  // Clear engine state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Clear engine next state: walk every cell once, then return to idle
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iCLEAR) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_idx_q == CNT_W'(CELLS - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // Writable board: clear engine has priority, user writes only while idle
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int k = 0; k < CELLS; k++) wr_board_q[k] <= '0;
    end else if (clr_we_s) begin
      wr_board_q[clr_idx_q] <= '0;
    end else if (usr_we_s) begin
      wr_board_q[cell_idx(iWR_ROW, iWR_COL)] <= iWR_VAL;
    end
  end

  // Registered read port (old data on same-cycle write)
  always_ff @(posedge iCLK) begin
    if (iRST) rd_val_q <= '0;
    else      rd_val_q <= wr_board_q[cell_idx(iRD_ROW, iRD_COL)];
  end

`ifdef TILE_GRID_SHADOW_EN
  logic [VAL_W-1:0] front_q [CELLS];
  logic             pending_q;
  logic             copy_s;

  assign copy_s = !busy_s && (iFRAME_START || pending_q);

  // Front board refresh; a frame start during a clear waits for the clear to finish
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int k = 0; k < CELLS; k++) front_q[k] <= '0;
      pending_q <= 1'b0;
    end else if (copy_s) begin
      front_q   <= wr_board_q;
      pending_q <= 1'b0;
    end else if (iFRAME_START) begin
      pending_q <= 1'b1;
    end
  end

  assign px_cell_s = front_q[cell_idx(s1_row_q, s1_col_q)];
`else
  logic unused_frame_s;
  assign unused_frame_s = iFRAME_START;
  assign px_cell_s      = wr_board_q[cell_idx(s1_row_q, s1_col_q)];
`endif

  // S1 decode: parallel compares against each column/row span
  always_comb begin
    col_hit_s = 1'b0;
    row_hit_s = 1'b0;
    col_s     = '0;
    row_s     = '0;
    rx_s      = '0;
    ry_s      = '0;
    for (int k = 0; k < GRID_N; k++) begin
      col_hit_s = col_hit_s | in_span(iPX, X_OFF, k);
      col_s     = in_span(iPX, X_OFF, k) ? IDX_W'(k) : col_s;
      rx_s      = in_span(iPX, X_OFF, k) ? (iPX - span_start(X_OFF, k)) : rx_s;
      row_hit_s = row_hit_s | in_span(iPY, Y_OFF, k);
      row_s     = in_span(iPY, Y_OFF, k) ? IDX_W'(k) : row_s;
      ry_s      = in_span(iPY, Y_OFF, k) ? (iPY - span_start(Y_OFF, k)) : ry_s;
    end
  end

  // S2 corner rule: distance from the inner corner-circle centre
  always_comb begin
    left_s   = s1_rx_q < COORD_W'(RADIUS);
    right_s  = s1_rx_q >= COORD_W'(BLOCK_DIM - RADIUS);
    top_s    = s1_ry_q < COORD_W'(RADIUS);
    bot_s    = s1_ry_q >= COORD_W'(BLOCK_DIM - RADIUS);
    dx_s     = left_s ? (COORD_W'(RADIUS) - s1_rx_q) : (s1_rx_q - COORD_W'(BLOCK_DIM - 1 - RADIUS));
    dy_s     = top_s  ? (COORD_W'(RADIUS) - s1_ry_q) : (s1_ry_q - COORD_W'(BLOCK_DIM - 1 - RADIUS));
    dsq_s    = PROD_W'(dx_s) * PROD_W'(dx_s) + PROD_W'(dy_s) * PROD_W'(dy_s);
    corner_s = (left_s || right_s) && (top_s || bot_s);
    keep_s   = !corner_s || (dsq_s <= PROD_W'(RADIUS * RADIUS));
  end

  // Three pipeline register stages
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_valid_q   <= 1'b0;
      s1_col_hit_q <= 1'b0;
      s1_row_hit_q <= 1'b0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s1_rx_q      <= '0;
      s1_ry_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_hit_q     <= 1'b0;
      s2_val_q     <= '0;
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_class_q  <= '0;
    end else begin
      s1_valid_q   <= iPX_VALID;
      s1_col_hit_q <= col_hit_s;
      s1_row_hit_q <= row_hit_s;
      s1_col_q     <= col_s;
      s1_row_q     <= row_s;
      s1_rx_q      <= rx_s;
      s1_ry_q      <= ry_s;
      s2_valid_q   <= s1_valid_q;
      s2_hit_q     <= s1_col_hit_q && s1_row_hit_q && keep_s;
      s2_val_q     <= px_cell_s;
      out_valid_q  <= s2_valid_q;
      out_hit_q    <= s2_valid_q && s2_hit_q;
      out_class_q  <= (s2_valid_q && s2_hit_q) ? s2_val_q : '0;
    end
  end

  assign oRD_VAL = rd_val_q;
  assign oBUSY   = busy_s;
  assign oVALID  = out_valid_q;
  assign oHIT    = out_hit_q;
  assign oCLASS  = out_class_q;

endmodule

// File: tb/tb_tile_grid_renderer.sv
// Scoreboard bench for tile_grid_renderer: stimulus pushes expectations, a negedge monitor checks them.
module tb_tile_grid_renderer;

  logic       iCLK = 1'b0;
  logic       iRST, iPX_VALID, iWR_EN, iCLEAR, iFRAME_START;
  logic [9:0] iPX, iPY;
  logic [1:0] iWR_ROW, iWR_COL, iRD_ROW, iRD_COL;
  logic [3:0] iWR_VAL, oRD_VAL, oCLASS;
  logic       oBUSY, oVALID, oHIT;

  typedef struct { int due; int hit; int cls; } px_exp_t;
  typedef struct { int due; int val; } rd_exp_t;

  px_exp_t px_q[$];
  rd_exp_t rd_q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  tile_grid_renderer dut (
    .iCLK(iCLK), .iRST(iRST), .iPX(iPX), .iPY(iPY), .iPX_VALID(iPX_VALID),
    .iWR_EN(iWR_EN), .iWR_ROW(iWR_ROW), .iWR_COL(iWR_COL), .iWR_VAL(iWR_VAL),
    .iRD_ROW(iRD_ROW), .iRD_COL(iRD_COL), .oRD_VAL(oRD_VAL),
    .iCLEAR(iCLEAR), .oBUSY(oBUSY), .iFRAME_START(iFRAME_START),
    .oVALID(oVALID), .oHIT(oHIT), .oCLASS(oCLASS)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop pixel results on oVALID, read results at their due cycle
  always @(negedge iCLK) begin : monitor
    px_exp_t pe;
    rd_exp_t re;
    if (mon_en) begin
      if (oVALID) begin
        if (px_q.size() == 0) begin
          chk("px_unexpected_valid", 1, 0);
        end else begin
          pe = px_q.pop_front();
          chk("px_latency", cyc, pe.due);
          chk("px_hit", int'(oHIT), pe.hit);
          chk("px_class", int'(oCLASS), pe.cls);
        end
      end else begin
        chk("idle_outputs", int'({oHIT, oCLASS}), 0);
        if (px_q.size() > 0 && px_q[0].due <= cyc) begin
          pe = px_q.pop_front();
          chk("px_missing_valid", 0, 1);
        end
      end
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        re = rd_q.pop_front();
        chk("rd_due", cyc, re.due);
        chk("rd_val", int'(oRD_VAL), re.val);
      end
    end
  end

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wr(input int r, input int c, input int v);
    iWR_ROW = 2'(r); iWR_COL = 2'(c); iWR_VAL = 4'(v); iWR_EN = 1'b1;
    step();
    iWR_EN = 1'b0;
  endtask

  task automatic px(input int x, input int y, input int h, input int c);
    iPX = 10'(x); iPY = 10'(y); iPX_VALID = 1'b1;
    px_q.push_back('{cyc + 3, h, c});
    step();
    iPX_VALID = 1'b0;
  endtask

  task automatic rd(input int r, input int c, input int v);
    iRD_ROW = 2'(r); iRD_COL = 2'(c);
    rd_q.push_back('{cyc + 1, v});
    step();
  endtask

  task automatic frame();
    iFRAME_START = 1'b1;
    step();
    iFRAME_START = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iPX_VALID = 1'b0; iWR_EN = 1'b0; iCLEAR = 1'b0; iFRAME_START = 1'b0;
    iPX = 10'd0; iPY = 10'd0; iWR_ROW = 2'd0; iWR_COL = 2'd0; iWR_VAL = 4'd0;
    iRD_ROW = 2'd0; iRD_COL = 2'd0;
    repeat (3) step();
    iRST = 1'b0;
    mon_en = 1'b1;
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_valid", int'(oVALID), 0);
    chk("rst_hit", int'(oHIT), 0);
    chk("rst_class", int'(oCLASS), 0);
    chk("rst_rdval", int'(oRD_VAL), 0);

    // Basic hit, margin miss, invalid coordinate
    wr(1, 2, 5);
    frame();
    px(218, 104, 1, 5);
    px(118, 20, 0, 0);
    iPX = 10'd218; iPY = 10'd104; iPX_VALID = 1'b0;
    step();

    // Rounded corners on tile (0,0) plus edges of the grid
    wr(0, 0, 3);
    frame();
    px(50, 10, 0, 0);
    px(51, 11, 1, 3);
    px(50, 13, 1, 3);
    px(113, 73, 0, 0);
    px(124, 84, 0, 0);
    px(125, 86, 1, 0);
    px(292, 252, 1, 0);
    px(335, 295, 0, 0);
    px(336, 252, 0, 0);
    px(113, 50, 1, 3);
    repeat (4) step();

`ifndef TILE_GRID_SHADOW_EN
    // Write and pixel in the same cycle: S2 sees the new value
    iWR_ROW = 2'd1; iWR_COL = 2'd1; iWR_VAL = 4'd10; iWR_EN = 1'b1;
    iPX = 10'd144; iPY = 10'd104; iPX_VALID = 1'b1;
    px_q.push_back('{cyc + 3, 1, 10});
    step();
    iWR_EN = 1'b0; iPX_VALID = 1'b0;
    repeat (4) step();
`endif

    // Fill, clear for 16 cycles, ignored write and ignored re-clear during busy
    for (int i = 0; i < 16; i++) wr(i / 4, i % 4, 7);
    rd(2, 2, 7);
    rd(3, 1, 7);
    iCLEAR = 1'b1;
    step();
    iCLEAR = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("busy_window", int'(oBUSY), 1);
      iWR_EN  = (i == 3);
      iWR_ROW = 2'd2; iWR_COL = 2'd2; iWR_VAL = 4'd9;
      iCLEAR  = (i == 5);
      step();
      iWR_EN = 1'b0; iCLEAR = 1'b0;
    end
    chk("busy_end", int'(oBUSY), 0);
    for (int i = 0; i < 16; i++) rd(i / 4, i % 4, 0);

    // Clear beats a simultaneous write
    wr(0, 1, 6);
    iCLEAR = 1'b1; iWR_ROW = 2'd0; iWR_COL = 2'd1; iWR_VAL = 4'd4; iWR_EN = 1'b1;
    step();
    iCLEAR = 1'b0; iWR_EN = 1'b0;
    rd(0, 1, 6);
    for (int i = 0; i < 40 && oBUSY; i++) step();
    chk("clear_done", int'(oBUSY), 0);
    rd(0, 1, 0);
    step();

    // Reset in the middle of a clear
    wr(3, 3, 8);
    wr(0, 0, 5);
    iCLEAR = 1'b1;
    step();
    iCLEAR = 1'b0;
    repeat (4) step();
    chk("busy_before_rst", int'(oBUSY), 1);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    chk("rst_mid_clear_busy", int'(oBUSY), 0);
    rd(3, 3, 0);
    rd(0, 0, 0);
    px(292, 252, 1, 0);
    repeat (4) step();

`ifdef TILE_GRID_SHADOW_EN
    // Shadow board: front holds until the next frame start
    wr(3, 3, 2);
    frame();
    wr(3, 3, 9);
    px(292, 252, 1, 2);
    rd(3, 3, 9);
    frame();
    px(292, 252, 1, 9);
`endif

    for (int i = 0; i < 20 && (px_q.size() > 0 || rd_q.size() > 0); i++) step();
    chk("drain_px", px_q.size(), 0);
    chk("drain_rd", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
